// File: rtl/calc_pkg.sv
// Shared definitions for the calculator IP: opcodes, FSM states and sizing constants.
// Used by calc_core, the register-file slave and the verification bench.
package calc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ITER_CNT   = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > 3'(OP_DIV));
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative MUL/DIV datapath: one bit of shift-add product or restoring quotient per step.
// The accumulator's low half starts as the multiplier/dividend and ends as product-low/quotient.
module calc_iter_unit #(
    parameter int DATA_WIDTH = calc_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_is_div,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_last_step,
    output logic [DATA_WIDTH-1:0] o_nxt_hi,
    output logic [DATA_WIDTH-1:0] o_nxt_lo
);
    import calc_pkg::*;

    localparam int CW = $clog2(ITER_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER_CNT - 1);

    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_div;
    logic [CW-1:0]         r_cnt;

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_mul_hi;
    logic [DATA_WIDTH-1:0] w_mul_lo;
    logic [DATA_WIDTH:0]   w_sh;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_div_hi;
    logic [DATA_WIDTH-1:0] w_div_lo;

    // MUL: conditionally add multiplicand into the high half, then shift the 65-bit value right.
    assign w_sum    = {1'b0, r_hi} + {1'b0, r_b};
    assign w_mul_hi = r_lo[0] ? w_sum[DATA_WIDTH:1] : {1'b0, r_hi[DATA_WIDTH-1:1]};
    assign w_mul_lo = {(r_lo[0] ? w_sum[0] : r_hi[0]), r_lo[DATA_WIDTH-1:1]};

    // DIV: the partial remainder stays below the divisor, so the shifted value fits in W+1 bits.
    assign w_sh     = {r_hi, r_lo[DATA_WIDTH-1]};
    assign w_ge     = (w_sh >= {1'b0, r_b});
    assign w_diff   = w_sh[DATA_WIDTH-1:0] - r_b;
    assign w_div_hi = w_ge ? w_diff : w_sh[DATA_WIDTH-1:0];
    assign w_div_lo = {r_lo[DATA_WIDTH-2:0], w_ge};

    assign o_nxt_hi    = r_div ? w_div_hi : w_mul_hi;
    assign o_nxt_lo    = r_div ? w_div_lo : w_mul_lo;
    assign o_last_step = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_div <= i_is_div;
            r_cnt <= CNT_LAST;
        end else if (i_step) begin
            r_hi  <= o_nxt_hi;
            r_lo  <= o_nxt_lo;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/calc_core.sv
// Calculator arithmetic engine: captures a request, runs ADD/SUB directly or MUL/DIV iteratively,
// and presents held result/status with a one-cycle done pulse.
module calc_core #(
    parameter int DATA_WIDTH = calc_pkg::DATA_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic [2:0]            opcode,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  err
);
    import calc_pkg::*;

    state_e                r_state;
    state_e                w_next;
    logic                  r_first;
    logic [2:0]            r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;

    logic                  w_accept;
    logic                  w_iter_op;
    logic                  w_load;
    logic                  w_step;
    logic                  w_fin_single;
    logic                  w_fin_iter;
    logic                  w_last_step;
    logic [DATA_WIDTH-1:0] w_nxt_hi;
    logic [DATA_WIDTH-1:0] w_nxt_lo;

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_s_res;
    logic [DATA_WIDTH-1:0] w_s_hi;
    logic                  w_s_err;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_iter_op = (r_op == OP_MUL) || ((r_op == OP_DIV) && (r_b != '0));
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

    // The first EXEC cycle after capture either resolves a single-cycle op or loads the iterator.
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fin_single = 1'b0;
        w_fin_iter   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                if (r_first) begin
                    if (w_iter_op) begin
                        w_load = 1'b1;
                    end else begin
                        w_fin_single = 1'b1;
                        w_next       = DONE;
                    end
                end else begin
                    w_step = 1'b1;
                    if (w_last_step) begin
                        w_fin_iter = 1'b1;
                        w_next     = DONE;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= w_accept;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= opcode;
            r_a  <= op_a;
            r_b  <= op_b;
        end
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = r_a - r_b;

    // Single-cycle results; DIV only reaches this path with a zero divisor.
    always_comb begin
        w_s_res = '0;
        w_s_hi  = '0;
        w_s_err = op_illegal(r_op);
        case (r_op)
            OP_ADD: begin
                w_s_res = w_sum[DATA_WIDTH-1:0];
                w_s_hi  = {{(DATA_WIDTH-1){1'b0}}, w_sum[DATA_WIDTH]};
            end
            OP_SUB: begin
                w_s_res = w_diff;
                w_s_hi  = {{(DATA_WIDTH-1){1'b0}}, (r_a < r_b)};
            end
            OP_DIV: begin
                w_s_res = '1;
                w_s_hi  = r_a;
                w_s_err = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            result    <= '0;
            result_hi <= '0;
            err       <= 1'b0;
        end else if (w_accept) begin
            err <= 1'b0;
        end else if (w_fin_single) begin
            result    <= w_s_res;
            result_hi <= w_s_hi;
            err       <= w_s_err;
        end else if (w_fin_iter) begin
            result    <= w_nxt_lo;
            result_hi <= w_nxt_hi;
        end
    end

    calc_iter_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_is_div    (r_op == OP_DIV),
        .i_a         (r_a),
        .i_b         (r_b),
        .o_last_step (w_last_step),
        .o_nxt_hi    (w_nxt_hi),
        .o_nxt_lo    (w_nxt_lo)
    );

endmodule
